// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A packed hex word is accepted over a valid/ready handshake into a one-deep
// pending buffer. That buffer is promoted to the displayed ("active") value
// only at a frame boundary, so a frame never shows a mix of two values.
// Each digit slot begins with a short all-dark blanking gap, which prevents
// ghosting between digits. The rest of the slot drives the digit's anode and
// its decoded segments.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   data       4*DIGITS hex value, digit i = data[4i+3:4i], digit 0 rightmost
//   data_vld   producer has data
//   data_rdy   pending buffer is empty (combinational)
//   digit_en   per-digit enable, 0 keeps the anode off (live)
//   dp         per-digit decimal point, 1 = lit (live)
//   blank_lz   1 = suppress leading zeros (live)
//   an         anode selects, active-low, registered
//   seg        {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_done one-cycle pulse the cycle after each frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  data_vld,
  output logic                  data_rdy,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {PH_BLANK = 1'b0, PH_DRIVE = 1'b1} phase_t;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_seg_decode(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_active;
  logic [4*DIGITS-1:0] r_pending;
  logic                r_pend_full;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;
  logic                r_frame_done;

  logic                w_div_wrap;
  logic                w_boundary;
  logic                w_xfer;
  phase_t              w_phase;
  logic [3:0]          w_nibble;
  logic [6:0]          w_code;
  logic                w_hi_zero;
  logic                w_suppress;

  assign data_rdy   = ~r_pend_full;
  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  // Slot timing, handshake qualification and digit suppression decision.
  always_comb begin
    w_div_wrap = (r_div_cnt == DIV_LAST);
    w_boundary = w_div_wrap && (r_idx == IDX_LAST);
    w_xfer     = data_vld && !r_pend_full;
    w_phase    = (r_div_cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    w_nibble   = r_active[4*r_idx +: 4];
    w_code     = f_seg_decode(w_nibble);
    // Current digit is a leading zero when it and every higher nibble is 0.
    w_hi_zero  = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      w_hi_zero = w_hi_zero & ~((j >= int'(r_idx)) & (|r_active[4*j +: 4]));
    end
    w_suppress = !digit_en[r_idx] ||
                 (blank_lz && (r_idx != {IDX_W{1'b0}}) && w_hi_zero);
  end

  // Dwell counter and digit index; disabled digits still take their slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
    end else if (w_div_wrap) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Pending/active buffers; active only changes at a frame boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active    <= {(4*DIGITS){1'b0}};
      r_pending   <= {(4*DIGITS){1'b0}};
      r_pend_full <= 1'b0;
    end else if (w_boundary && r_pend_full) begin
      r_active    <= r_pending;
      r_pend_full <= 1'b0;
    end else if (w_boundary && w_xfer) begin
      // Empty buffer at the boundary: the new word goes straight to display.
      r_active    <= data;
    end else if (w_xfer) begin
      r_pending   <= data;
      r_pend_full <= 1'b1;
    end else begin
      r_pend_full <= r_pend_full;
    end
  end

  // Registered anode/segment drive and frame pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an         <= {DIGITS{1'b1}};
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if ((w_phase == PH_BLANK) || w_suppress) begin
        r_an  <= {DIGITS{1'b1}};
        r_seg <= 8'hFF;
      end else begin
        r_an  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
        r_seg <= {~dp[r_idx], w_code};
      end
    end
  end

endmodule
